// File: rtl/om_pkg.sv
// Shared types for the object-range recorder: record layout, FSM states and
// the inclusive last-address helper.
package om_pkg;

  typedef struct packed {
    logic [31:0] first;
    logic [31:0] last;
  } range_rec_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IN_CALL = 2'd1,
    EMIT    = 2'd2
  } rec_state_e;

  localparam logic [31:0] NULL_ADDR = 32'h0;

  // base + size - 1 in 33 bits; a carry out saturates to the top of memory.
  function automatic logic [31:0] calc_last(input logic [31:0] base,
                                            input logic [31:0] size);
    logic [32:0] sum;
    sum = {1'b0, base} + {1'b0, size} - 33'd1;
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/range_rec_fifo.sv
// Synchronous FIFO of range records; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module range_rec_fifo
  import om_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  range_rec_t data_i,
  input  logic       pop_i,
  output range_rec_t data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, rd_ptr_q;
  range_rec_t  mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Storage is cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/alloc_range_recorder.sv
// Captures allocator call size and return base from the commit stream and
// queues {first,last} records. ALLOC_RECORDER_STATS_EN adds record/drop counters.
module alloc_range_recorder
  import om_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int DEPTH_W    = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        commit_valid_i,
  input  logic        commit_is_call_i,
  input  logic        commit_is_ret_i,
  input  logic [31:0] commit_target_i,
  input  logic [31:0] a0_i,
  input  logic [31:0] malloc_addr_i,
  output logic        wr_valid_o,
  input  logic        wr_ready_i,
  output logic [31:0] addr_first_o,
  output logic [31:0] addr_last_o,
  output logic        overflow_o,
  output logic        depth_err_o,
  output rec_state_e  state_o
`ifdef ALLOC_RECORDER_STATS_EN
  ,
  output logic [31:0] rec_count_o,
  output logic [31:0] drop_count_o
`endif
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

  rec_state_e         state_q;
  logic [31:0]        size_q, base_q;
  logic [DEPTH_W-1:0] depth_q;
  logic               overflow_q, depth_err_q;

  logic       call_ev, ret_ev, malloc_hit;
  logic       emit, rec_ok, push_req, pop, drop_ovf, sat_err;
  logic       fifo_full, fifo_empty;
  range_rec_t push_rec, head_rec;

  assign call_ev    = commit_valid_i && commit_is_call_i;
  assign ret_ev     = commit_valid_i && commit_is_ret_i;
  assign malloc_hit = call_ev && (commit_target_i == malloc_addr_i) &&
                      (malloc_addr_i != NULL_ADDR);

  // A flush during EMIT discards the captured record along with the state.
  assign emit     = (state_q == EMIT) && !flush_i;
  assign rec_ok   = (size_q != 32'h0) && (base_q != NULL_ADDR);
  assign push_req = emit && rec_ok;
  assign pop      = wr_valid_o && wr_ready_i;
  assign drop_ovf = push_req && fifo_full && !pop;
  assign sat_err  = (state_q == IN_CALL) && !flush_i && call_ev &&
                    (depth_q == DEPTH_MAX);

  assign push_rec.first = base_q;
  assign push_rec.last  = calc_last(base_q, size_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      size_q      <= '0;
      base_q      <= '0;
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      depth_err_q <= 1'b0;
    end else begin
      if (drop_ovf) overflow_q <= 1'b1;
      if (flush_i) begin
        state_q <= IDLE;
        size_q  <= '0;
        base_q  <= '0;
        depth_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (malloc_hit) begin
              size_q  <= a0_i;
              depth_q <= '0;
              state_q <= IN_CALL;
            end
          end
          IN_CALL: begin
            if (call_ev) begin
              if (depth_q == DEPTH_MAX) begin
                depth_err_q <= 1'b1;
                state_q     <= IDLE;
              end else begin
                depth_q <= depth_q + DEPTH_W'(1);
              end
            end else if (ret_ev) begin
              if (depth_q != '0) begin
                depth_q <= depth_q - DEPTH_W'(1);
              end else begin
                base_q  <= a0_i;
                state_q <= EMIT;
              end
            end
          end
          EMIT:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  range_rec_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_req),
    .data_i  (push_rec),
    .pop_i   (pop),
    .data_o  (head_rec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign wr_valid_o   = !fifo_empty;
  assign addr_first_o = head_rec.first;
  assign addr_last_o  = head_rec.last;
  assign overflow_o   = overflow_q;
  assign depth_err_o  = depth_err_q;
  assign state_o      = state_q;

`ifdef ALLOC_RECORDER_STATS_EN
  logic [31:0] rec_count_q, drop_count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rec_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      if (pop) rec_count_q <= rec_count_q + 32'd1;
      if ((emit && !rec_ok) || drop_ovf || sat_err)
        drop_count_q <= drop_count_q + 32'd1;
    end
  end

  assign rec_count_o  = rec_count_q;
  assign drop_count_o = drop_count_q;
`endif

endmodule

// File: tb/tb_alloc_range_recorder.sv
// Directed bench for alloc_range_recorder: queue-level reference model checked
// every cycle, plus literal expectations for the documented scenarios.
module tb_alloc_range_recorder;
  import om_pkg::*;

  localparam logic [31:0] MALLOC = 32'h0000_1000;
  localparam int          FDEPTH = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        commit_valid_i, commit_is_call_i, commit_is_ret_i;
  logic [31:0] commit_target_i, a0_i, malloc_addr_i;
  logic        wr_valid_o, wr_ready_i;
  logic [31:0] addr_first_o, addr_last_o;
  logic        overflow_o, depth_err_o;
  rec_state_e  state_o;
`ifdef ALLOC_RECORDER_STATS_EN
  logic [31:0] rec_count_o, drop_count_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Clock / reset
  always #5 clk_i = ~clk_i;

  alloc_range_recorder #(.FIFO_DEPTH(FDEPTH), .DEPTH_W(4)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .commit_valid_i   (commit_valid_i),
    .commit_is_call_i (commit_is_call_i),
    .commit_is_ret_i  (commit_is_ret_i),
    .commit_target_i  (commit_target_i),
    .a0_i             (a0_i),
    .malloc_addr_i    (malloc_addr_i),
    .wr_valid_o       (wr_valid_o),
    .wr_ready_i       (wr_ready_i),
    .addr_first_o     (addr_first_o),
    .addr_last_o      (addr_last_o),
    .overflow_o       (overflow_o),
    .depth_err_o      (depth_err_o),
    .state_o          (state_o)
`ifdef ALLOC_RECORDER_STATS_EN
    ,
    .rec_count_o      (rec_count_o),
    .drop_count_o     (drop_count_o)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: allocation tracking as nesting count + pending record,
  // buffer as a bounded queue of {first,last}.
  logic [63:0] exp_q[$];
  bit          m_active, m_pend, m_emitting, m_ovf, m_err;
  int          m_nest;
  logic [31:0] m_size, m_psize, m_pbase;
  int unsigned m_acc, m_drop;
  longint      m_sum;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_q.delete();
      m_active = 0; m_pend = 0; m_ovf = 0; m_err = 0; m_nest = 0;
      m_size = 0; m_psize = 0; m_pbase = 0; m_acc = 0; m_drop = 0;
    end else begin
      if (exp_q.size() != 0 && wr_ready_i) begin
        void'(exp_q.pop_front());
        m_acc++;
      end
      m_emitting = m_pend;
      if (m_pend) begin
        m_pend = 0;
        if (!flush_i) begin
          if (m_psize == 0 || m_pbase == 0) m_drop++;
          else if (exp_q.size() >= FDEPTH) begin m_ovf = 1; m_drop++; end
          else begin
            m_sum = longint'(m_pbase) + longint'(m_psize) - 1;
            if (m_sum > 64'sh0_FFFF_FFFF) m_sum = 64'sh0_FFFF_FFFF;
            exp_q.push_back({m_pbase, m_sum[31:0]});
          end
        end
      end
      if (flush_i) m_active = 0;
      else if (commit_valid_i && !m_emitting) begin
        if (!m_active) begin
          if (commit_is_call_i && commit_target_i == malloc_addr_i && malloc_addr_i != 0) begin
            m_active = 1; m_size = a0_i; m_nest = 0;
          end
        end else if (commit_is_call_i) begin
          if (m_nest == 15) begin m_err = 1; m_active = 0; m_drop++; end
          else m_nest++;
        end else if (commit_is_ret_i) begin
          if (m_nest > 0) m_nest--;
          else begin m_pend = 1; m_pbase = a0_i; m_psize = m_size; m_active = 0; end
        end
      end
    end
  end

  // Scoreboard compare every cycle, away from the active edge.
  always @(negedge clk_i) begin
    chk("wr_valid", 64'(wr_valid_o), 64'(exp_q.size() != 0));
    chk("overflow", 64'(overflow_o), 64'(m_ovf));
    chk("depth_err", 64'(depth_err_o), 64'(m_err));
    if (exp_q.size() != 0) chk("head", {addr_first_o, addr_last_o}, exp_q[0]);
`ifdef ALLOC_RECORDER_STATS_EN
    chk("rec_count", 64'(rec_count_o), 64'(m_acc));
    chk("drop_count", 64'(drop_count_o), 64'(m_drop));
`endif
  end

  // Driver tasks
  task automatic commit(input logic is_call, input logic is_ret, input logic [31:0] tgt,
                        input logic [31:0] a0, input logic fl);
    commit_valid_i   = 1'b1;
    commit_is_call_i = is_call;
    commit_is_ret_i  = is_ret;
    commit_target_i  = tgt;
    a0_i             = a0;
    flush_i          = fl;
    @(negedge clk_i);
    commit_valid_i   = 1'b0;
    commit_is_call_i = 1'b0;
    commit_is_ret_i  = 1'b0;
    commit_target_i  = '0;
    a0_i             = '0;
    flush_i          = 1'b0;
  endtask

  // Call, return, then wait through the emit cycle.
  task automatic alloc(input logic [31:0] size, input logic [31:0] base);
    commit(1'b1, 1'b0, MALLOC, size, 1'b0);
    commit(1'b0, 1'b1, 32'h0, base, 1'b0);
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; commit_valid_i = 1'b0; commit_is_call_i = 1'b0;
    commit_is_ret_i = 1'b0; commit_target_i = '0; a0_i = '0;
    malloc_addr_i = MALLOC; wr_ready_i = 1'b1;
    idle(2);
    chk("reset_valid", 64'(wr_valid_o), 64'd0);
    chk("reset_head", {addr_first_o, addr_last_o}, 64'd0);
    chk("reset_state", 64'(state_o), 64'(IDLE));
    rst_ni = 1'b1;
    idle(2);

    // Basic record, valid two cycles after the return
    commit(1'b1, 1'b0, MALLOC, 32'h40, 1'b0);
    chk("basic_in_call", 64'(state_o), 64'(IN_CALL));
    commit(1'b0, 1'b1, 32'h0, 32'h8000_0100, 1'b0);
    chk("basic_valid_n1", 64'(wr_valid_o), 64'd0);
    @(negedge clk_i);
    chk("basic_valid_n2", 64'(wr_valid_o), 64'd1);
    chk("basic_rec", {addr_first_o, addr_last_o}, 64'h8000_0100_8000_013F);
    idle(2);

    // Nested calls: inner return ignored
    commit(1'b1, 1'b0, MALLOC, 32'h10, 1'b0);
    commit(1'b1, 1'b0, 32'h5000, 32'h99, 1'b0);
    commit(1'b0, 1'b1, 32'h0, 32'h1234, 1'b0);
    idle(2);
    chk("nested_no_inner", 64'(wr_valid_o), 64'd0);
    commit(1'b0, 1'b1, 32'h0, 32'h2000, 1'b0);
    @(negedge clk_i);
    chk("nested_rec", {addr_first_o, addr_last_o}, 64'h0000_2000_0000_200F);
    idle(2);

    // Size zero and NULL return are suppressed
    alloc(32'h0, 32'h3000);
    chk("size0_valid", 64'(wr_valid_o), 64'd0);
    alloc(32'h20, 32'h0);
    chk("null_valid", 64'(wr_valid_o), 64'd0);

    // Saturating last address
    alloc(32'h40, 32'hFFFF_FFF0);
    chk("sat_rec", {addr_first_o, addr_last_o}, 64'hFFFF_FFF0_FFFF_FFFF);
    idle(2);

    // Allocator disabled by zero entry address
    malloc_addr_i = 32'h0;
    commit(1'b1, 1'b0, 32'h0, 32'h10, 1'b0);
    commit(1'b0, 1'b1, 32'h0, 32'h9000, 1'b0);
    idle(2);
    chk("disabled_valid", 64'(wr_valid_o), 64'd0);
    malloc_addr_i = MALLOC;

    // Backpressure: two held, third dropped
    wr_ready_i = 1'b0;
    alloc(32'h10, 32'h100);
    alloc(32'h20, 32'h200);
    chk("bp_stable", {addr_first_o, addr_last_o}, 64'h0000_0100_0000_010F);
    alloc(32'h30, 32'h300);
    chk("bp_overflow", 64'(overflow_o), 64'd1);
    chk("bp_head", {addr_first_o, addr_last_o}, 64'h0000_0100_0000_010F);
    wr_ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp_second", {addr_first_o, addr_last_o}, 64'h0000_0200_0000_021F);
    @(negedge clk_i);
    chk("bp_drained", 64'(wr_valid_o), 64'd0);

    // Flush on the matching return
    commit(1'b1, 1'b0, MALLOC, 32'h80, 1'b0);
    commit(1'b0, 1'b1, 32'h0, 32'h4000, 1'b1);
    chk("flush_state", 64'(state_o), 64'(IDLE));
    @(negedge clk_i);
    chk("flush_valid", 64'(wr_valid_o), 64'd0);
    alloc(32'h8, 32'h5000);
    chk("post_flush_rec", {addr_first_o, addr_last_o}, 64'h0000_5000_0000_5007);
    idle(2);

    // Depth saturation abandons the capture
    commit(1'b1, 1'b0, MALLOC, 32'h10, 1'b0);
    for (int i = 0; i < 15; i++) commit(1'b1, 1'b0, 32'h6000, 32'h0, 1'b0);
    chk("depth_no_err", 64'(depth_err_o), 64'd0);
    commit(1'b1, 1'b0, 32'h6000, 32'h0, 1'b0);
    chk("depth_err", 64'(depth_err_o), 64'd1);
    chk("depth_state", 64'(state_o), 64'(IDLE));
    commit(1'b0, 1'b1, 32'h0, 32'h7000, 1'b0);
    idle(2);
    chk("depth_no_rec", 64'(wr_valid_o), 64'd0);

    // Async reset mid-capture with one queued record
    wr_ready_i = 1'b0;
    alloc(32'h10, 32'h6000);
    commit(1'b1, 1'b0, MALLOC, 32'h20, 1'b0);
    chk("pre_rst_state", 64'(state_o), 64'(IN_CALL));
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_valid", 64'(wr_valid_o), 64'd0);
    chk("rst_head", {addr_first_o, addr_last_o}, 64'd0);
    chk("rst_flags", {62'd0, overflow_o, depth_err_o}, 64'd0);
    chk("rst_state", 64'(state_o), 64'(IDLE));
    @(negedge clk_i);
    rst_ni = 1'b1;
    wr_ready_i = 1'b1;
    commit(1'b0, 1'b1, 32'h0, 32'h7000, 1'b0);
    idle(3);
    chk("rst_no_rec", 64'(wr_valid_o), 64'd0);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
